// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order MIPS pipeline. A shadow
// scoreboard tracks in-flight destinations so write addresses need no feedback.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int REG_AW       = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 16,
    parameter int DEBUG        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs_addr,
    input  logic                          id_rs_used,
    input  logic [REG_AW-1:0]             id_rt_addr,
    input  logic                          id_rt_used,
    input  logic                          id_wen,
    input  logic [REG_AW-1:0]             id_waddr,
    input  logic                          id_is_load,
    input  logic                          id_is_branch,
    input  logic                          branch_taken,
    input  logic                          debug_en,
    input  logic                          debug_step,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_rst,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_a_sel,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_b_sel,
    output logic                          stall,
    output logic                          flush,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int SW = $clog2(NUM_STAGES);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] waddr;
        logic              isLoad;
        logic              isBranch;
    } rec_t;

    rec_t r_rec [2:NUM_STAGES-1];
    rec_t w_idRec;

    logic             r_stepPrev;
    logic             w_stepEdge;
    logic             w_hold;
    logic [1:0]       w_match;
    logic [1:0]       w_loadUse;
    logic [1:0]       w_haz;
    logic [1:0]       w_srcUsed;
    logic [REG_AW-1:0] w_srcAddr [2];
    logic [SW-1:0]    w_sel [2];
    logic             w_stallRaw;
    logic             w_flushRaw;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    assign w_stepEdge = debug_step & ~r_stepPrev;
    assign w_hold     = (DEBUG != 0) & debug_en & ~w_stepEdge;

    assign w_idRec = id_valid ? '{valid: 1'b1, wen: id_wen, waddr: id_waddr,
                                  isLoad: id_is_load, isBranch: id_is_branch} : '0;

    assign w_srcAddr[0] = id_rs_addr;
    assign w_srcAddr[1] = id_rt_addr;
    assign w_srcUsed    = {id_rt_used, id_rs_used};

    // Scan oldest to youngest so the youngest matching producer wins; the
    // last stage writes through the register file and is never a source.
    always_comb begin
        w_match   = '0;
        w_loadUse = '0;
        for (int s = 0; s < 2; s++) begin
            w_sel[s] = '0;
            for (int k = NUM_STAGES - 2; k >= 2; k--) begin
                if (w_srcUsed[s] && (w_srcAddr[s] != '0) && r_rec[k].valid &&
                    r_rec[k].wen && (r_rec[k].waddr == w_srcAddr[s])) begin
                    w_match[s]   = 1'b1;
                    w_sel[s]     = SW'(k);
                    w_loadUse[s] = (k == 2) && r_rec[k].isLoad;
                end
            end
        end
    end

    assign w_haz      = (FWD_EN != 0) ? w_loadUse : w_match;
    assign w_stallRaw = (|w_haz) & id_valid;
    assign w_flushRaw = branch_taken & r_rec[BRANCH_STAGE].valid & r_rec[BRANCH_STAGE].isBranch;

    assign stall     = ~rst & w_stallRaw & ~w_flushRaw;
    assign flush     = ~rst & w_flushRaw;
    assign fwd_a_sel = ((FWD_EN != 0) && !rst) ? w_sel[0] : '0;
    assign fwd_b_sel = ((FWD_EN != 0) && !rst) ? w_sel[1] : '0;

    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (rst) begin
            stage_rst = '1;
        end else if (w_hold) begin
            stage_en = '0;
        end else if (w_flushRaw) begin
            for (int k = 1; k <= BRANCH_STAGE; k++) begin
                stage_rst[k] = 1'b1;
            end
        end else if (w_stallRaw) begin
            stage_en[0]  = 1'b0;
            stage_en[1]  = 1'b0;
            stage_rst[2] = 1'b1;
        end
    end

    // Records follow the same enable/clear controls as the datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 2; k < NUM_STAGES; k++) begin
                r_rec[k] <= '0;
            end
        end else begin
            if (stage_rst[2]) begin
                r_rec[2] <= '0;
            end else if (stage_en[2]) begin
                r_rec[2] <= w_idRec;
            end
            for (int k = 3; k < NUM_STAGES; k++) begin
                if (stage_rst[k]) begin
                    r_rec[k] <= '0;
                end else if (stage_en[k]) begin
                    r_rec[k] <= r_rec[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stepPrev <= 1'b0;
        end else begin
            r_stepPrev <= debug_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (stall && !w_hold && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (flush && !w_hold && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, no-forwarding, and a
// 4-bit-counter variant share one stimulus stream; each test checks one of them.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs_addr = '0;
    logic       id_rs_used = 1'b0;
    logic [4:0] id_rt_addr = '0;
    logic       id_rt_used = 1'b0;
    logic       id_wen = 1'b0;
    logic [4:0] id_waddr = '0;
    logic       id_is_load = 1'b0;
    logic       id_is_branch = 1'b0;
    logic       branch_taken = 1'b0;
    logic       debug_en = 1'b0;
    logic       debug_step = 1'b0;

    logic [4:0]  enF, rstF, enN, rstN, enS, rstS;
    logic [2:0]  faF, fbF, faN, fbN, faS, fbS;
    logic        stallF, flushF, stallN, flushN, stallS, flushS;
    logic [15:0] scF, fcF, scN, fcN;
    logic [3:0]  scS, fcS;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FWD_EN(1)) dutFwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
        .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .debug_en(debug_en), .debug_step(debug_step), .stage_en(enF),
        .stage_rst(rstF), .fwd_a_sel(faF), .fwd_b_sel(fbF), .stall(stallF),
        .flush(flushF), .stall_cnt(scF), .flush_cnt(fcF));

    pipeline_hazard_ctrl #(.FWD_EN(0)) dutNoFwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
        .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .debug_en(debug_en), .debug_step(debug_step), .stage_en(enN),
        .stage_rst(rstN), .fwd_a_sel(faN), .fwd_b_sel(fbN), .stall(stallN),
        .flush(flushN), .stall_cnt(scN), .flush_cnt(fcN));

    pipeline_hazard_ctrl #(.FWD_EN(1), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
        .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .debug_en(debug_en), .debug_step(debug_step), .stage_en(enS),
        .stage_rst(rstS), .fwd_a_sel(faS), .fwd_b_sel(fbS), .stall(stallS),
        .flush(flushS), .stall_cnt(scS), .flush_cnt(fcS));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic rsU,
                                 input logic [4:0] rt, input logic rtU, input logic w,
                                 input logic [4:0] wa, input logic ld, input logic br);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rs_used   = rsU;
        id_rt_addr   = rt;
        id_rt_used   = rtU;
        id_wen       = w;
        id_waddr     = wa;
        id_is_load   = ld;
        id_is_branch = br;
    endtask

    task automatic doReset();
        rst = 1'b1;
        branch_taken = 1'b0;
        debug_en = 1'b0;
        debug_step = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1, 5'd3, 1, 5'd4, 1, 1, 5'd3, 0, 0);
        #1;
        checks++; if (enF !== 5'h1f || rstF !== 5'h1f) begin failures++;
            $display("[TB] FAIL reset_ctrl en=%b rst=%b expected 11111/11111", enF, rstF); end
        tick();
        #1;
        checks++; if (stallF !== 1'b0 || flushF !== 1'b0 || faF !== 3'd0 || fbF !== 3'd0) begin failures++;
            $display("[TB] FAIL reset_outs stall=%b flush=%b fa=%0d fb=%0d expected all 0", stallF, flushF, faF, fbF); end
        checks++; if (scF !== 16'd0 || fcF !== 16'd0) begin failures++;
            $display("[TB] FAIL reset_cnt stall_cnt=%0d flush_cnt=%0d expected 0/0", scF, fcF); end
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        doReset();
        applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
        #1;
        checks++; if (faF !== 3'd0 || stallF !== 1'b0) begin failures++;
            $display("[TB] FAIL fwd_first fa=%0d stall=%b expected 0/0", faF, stallF); end
        tick();
        applyStimulus(1, 5'd3, 1, 5'd6, 1, 1, 5'd5, 0, 0);
        #1;
        checks++; if (faF !== 3'd2 || fbF !== 3'd0 || stallF !== 1'b0 || enF !== 5'h1f) begin failures++;
            $display("[TB] FAIL fwd_k2 fa=%0d fb=%0d stall=%b en=%b expected 2/0/0/11111", faF, fbF, stallF, enF); end
        tick();
        applyStimulus(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        #1;
        checks++; if (faF !== 3'd3 || stallF !== 1'b0) begin failures++;
            $display("[TB] FAIL fwd_k3 fa=%0d stall=%b expected 3/0", faF, stallF); end
    endtask

    task automatic test_load_use();
        doReset();
        applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 1, 0);
        tick();
        applyStimulus(1, 5'd1, 1, 5'd4, 1, 1, 5'd6, 0, 0);
        #1;
        checks++; if (stallF !== 1'b1 || rstF !== 5'b00100 || enF !== 5'b11100) begin failures++;
            $display("[TB] FAIL load_use stall=%b rst=%b en=%b expected 1/00100/11100", stallF, rstF, enF); end
        tick();
        #1;
        checks++; if (stallF !== 1'b0 || fbF !== 3'd3 || scF !== 16'd1) begin failures++;
            $display("[TB] FAIL load_use_after stall=%b fb=%0d cnt=%0d expected 0/3/1", stallF, fbF, scF); end
    endtask

    task automatic test_no_fwd_stall();
        doReset();
        applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
        tick();
        applyStimulus(1, 5'd3, 1, 5'd6, 1, 1, 5'd5, 0, 0);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (stallN !== 1'b1 || faN !== 3'd0 || fbN !== 3'd0) begin failures++;
                $display("[TB] FAIL nofwd_stall%0d stall=%b fa=%0d fb=%0d expected 1/0/0", c, stallN, faN, fbN); end
            tick();
        end
        #1;
        checks++; if (stallN !== 1'b0 || scN !== 16'd2) begin failures++;
            $display("[TB] FAIL nofwd_release stall=%b cnt=%0d expected 0/2", stallN, scN); end
    endtask

    task automatic test_branch_flush();
        doReset();
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd31, 0, 1);
        tick();
        applyStimulus(1, 5'd31, 1, 5'd0, 0, 1, 5'd7, 0, 0);
        branch_taken = 1'b1;
        #1;
        checks++; if (flushN !== 1'b1 || stallN !== 1'b0 || rstN !== 5'b00110 || enN !== 5'h1f) begin failures++;
            $display("[TB] FAIL flush flush=%b stall=%b rst=%b en=%b expected 1/0/00110/11111", flushN, stallN, rstN, enN); end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (flushN !== 1'b0 || fcN !== 16'd1) begin failures++;
            $display("[TB] FAIL flush_ignored flush=%b cnt=%0d expected 0/1", flushN, fcN); end
        branch_taken = 1'b0;
    endtask

    task automatic test_zero_reg();
        doReset();
        applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd0, 1, 0);
        tick();
        applyStimulus(1, 5'd0, 1, 5'd0, 1, 1, 5'd8, 0, 0);
        #1;
        checks++; if (stallN !== 1'b0 || stallF !== 1'b0 || faF !== 3'd0 || fbF !== 3'd0) begin failures++;
            $display("[TB] FAIL zero_reg stallN=%b stallF=%b fa=%0d fb=%0d expected 0/0/0/0", stallN, stallF, faF, fbF); end
    endtask

    task automatic test_debug_step();
        doReset();
        debug_en = 1'b1;
        applyStimulus(1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (enF !== 5'd0 || rstF !== 5'd0 || faF !== 3'd0) begin failures++;
                $display("[TB] FAIL dbg_hold%0d en=%b rst=%b fa=%0d expected 0/0/0", c, enF, rstF, faF); end
            tick();
        end
        debug_step = 1'b1;
        #1;
        checks++; if (enF !== 5'h1f) begin failures++;
            $display("[TB] FAIL dbg_step en=%b expected 11111", enF); end
        tick();
        applyStimulus(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) debug_step = 1'b0;
            #1;
            checks++; if (enF !== 5'd0 || faF !== 3'd2) begin failures++;
                $display("[TB] FAIL dbg_after%0d en=%b fa=%0d expected 0/2", c, enF, faF); end
            tick();
        end
        debug_en = 1'b0;
        #1;
        checks++; if (enF !== 5'h1f || faF !== 3'd2) begin failures++;
            $display("[TB] FAIL dbg_release en=%b fa=%0d expected 11111/2", enF, faF); end
        tick();
        #1;
        checks++; if (faF !== 3'd3) begin failures++;
            $display("[TB] FAIL dbg_resume fa=%0d expected 3", faF); end
    endtask

    task automatic test_counter_saturation();
        doReset();
        applyStimulus(1, 5'd4, 1, 5'd0, 0, 1, 5'd4, 1, 0);
        for (int c = 0; c < 40; c++) begin
            if (c == 10) begin
                checks++; if (scS !== 4'd5) begin failures++;
                    $display("[TB] FAIL sat_mid cnt=%0d expected 5", scS); end
            end
            tick();
        end
        #1;
        checks++; if (scS !== 4'd15 || stallS !== 1'b0) begin failures++;
            $display("[TB] FAIL sat_full cnt=%0d stall=%b expected 15/0", scS, stallS); end
        tick();
        #1;
        checks++; if (stallS !== 1'b1 || scS !== 4'd15) begin failures++;
            $display("[TB] FAIL sat_hold stall=%b cnt=%0d expected 1/15", stallS, scS); end
        rst = 1'b1;
        #1;
        checks++; if (stallS !== 1'b0 || rstS !== 5'h1f || enS !== 5'h1f) begin failures++;
            $display("[TB] FAIL rst_mid stall=%b rst=%b en=%b expected 0/11111/11111", stallS, rstS, enS); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (stallS !== 1'b0 || faS !== 3'd0 || scS !== 4'd0 || fcS !== 4'd0) begin failures++;
            $display("[TB] FAIL rst_clear stall=%b fa=%0d scnt=%0d fcnt=%0d expected 0/0/0/0", stallS, faS, scS, fcS); end
    endtask

    initial begin
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_no_fwd_stall();
        test_branch_flush();
        test_zero_reg();
        test_debug_step();
        test_counter_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised pipeline-control unit for the in-order MIPS pipeline. It supersedes the fixed 5-stage stall-only controller.
- Tracks the destination registers of in-flight instructions internally in a shadow scoreboard, so the datapath no longer feeds write addresses back.
- Produces per-stage enable and reset controls, operand forwarding selects, load-use and branch-flush handling, and debug single-step.
- Keeps saturating stall and flush performance counters.
- Sits beside the instruction decoder. It consumes decoded ID-stage fields and the branch-resolution result.

Parameters:
- NUM_STAGES, 5, total stages. Stage 0=IF, 1=ID, 2..NUM_STAGES-1 downstream; legal range 4..8.
- REG_AW, 5, register address width.
- BRANCH_STAGE, 2, stage in which branches resolve; legal range 2..NUM_STAGES-2.
- FWD_EN, 1, 1=forwarding enabled; 0=stall on every RAW hazard.
- CNT_W, 16, width of each performance counter.
- DEBUG, 1, 1=debug hold/step logic present; 0=debug_en ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  REG_AW  source A address
- id_rs_used  in  1  source A read
- id_rt_addr  in  REG_AW  source B address
- id_rt_used  in  1  source B read
- id_wen  in  1  ID instruction writes a register
- id_waddr  in  REG_AW  destination address
- id_is_load  in  1  ID instruction is a load
- id_is_branch  in  1  ID instruction is a jump or branch
- branch_taken  in  1  instruction in BRANCH_STAGE redirects PC (combinational from datapath)
- debug_en  in  1  debug hold mode
- debug_step  in  1  step request; its rising edge advances one cycle
- stage_en  out  NUM_STAGES  bit k enables the pipeline register feeding stage k (bit 0 = PC)
- stage_rst  out  NUM_STAGES  bit k clears that register to a bubble
- fwd_a_sel  out  $clog2(NUM_STAGES)  0=register file, k=forward from output of stage k
- fwd_b_sel  out  $clog2(NUM_STAGES)  same encoding, for rt
- stall  out  1  load-use/RAW stall active this cycle
- flush  out  1  branch flush active this cycle
- stall_cnt  out  CNT_W  stall cycles counted
- flush_cnt  out  CNT_W  flush events counted

Behaviour:
- Scoreboard: record rec[k] for k=2..NUM_STAGES-1, each {valid,wen,waddr,is_load,is_branch}.
  - On an advancing edge (stage_en[2]=1): rec[2] takes the ID fields, or a bubble if stall/flush/!id_valid; rec[k+1]<=rec[k].
  - Records honour stage_rst/stage_en exactly as the datapath registers do.
- Hazard match for a source s (s used, address !=0): youngest k in 2..NUM_STAGES-2 with rec[k].valid & wen & waddr==s. Stage NUM_STAGES-1 writes the register file write-through and never matches.
- FWD_EN=1:
  - Match at k=2 with is_load is a load-use stall.
  - Any other match sets sel=k.
  - No match sets sel=0.
- FWD_EN=0: any match stalls; sels are held at 0.
- stall=(rs or rt hazard) & id_valid.
- flush=branch_taken & rec[BRANCH_STAGE].valid & rec[BRANCH_STAGE].is_branch. branch_taken without a valid branch record is ignored.
- Control priority, highest first:
  - rst: stage_rst all 1, stage_en all 1.
  - Debug hold (DEBUG=1, debug_en, no rising edge of debug_step): stage_en all 0, stage_rst 0, records frozen.
  - flush: stage_rst[1..BRANCH_STAGE]=1, all enables 1, PC loads target. Flush overrides a coincident stall; stall output reads 0.
  - stall: stage_en[0]=stage_en[1]=0, stage_rst[2]=1, other enables 1.
  - Otherwise: all enables 1, all resets 0.
- Debug edge detector register resets to 0. A step held high advances exactly one cycle.
- Counters:
  - stall_cnt +1 on each cycle stall is asserted and not in debug hold.
  - flush_cnt +1 per flush cycle.
  - Both saturate at all-ones and clear on rst.
- Reset values: stage_rst all 1, stage_en all 1, fwd sels 0, stall 0, flush 0, counters 0, all records invalid. Reset mid-stall or mid-flush discards all state.
- fwd sels, stall and flush are combinational from current records and ID inputs. Zero latency.

Test Plan:
- ADD r3 then ADD using r3 as rs, FWD_EN=1 -> fwd_a_sel=2, stall=0; next cycle an unrelated use of r3 gives fwd_a_sel=3.
- LW r4 then ADD using r4 as rt -> stall=1 for exactly one cycle with stage_rst[2]=1, then fwd_b_sel=3; stall_cnt=1.
- Same ADD-ADD sequence with FWD_EN=0 -> stall for NUM_STAGES-3=2 cycles, sels stay 0; stall_cnt=2.
- Taken BEQ reaching stage 2 with a hazard in ID the same cycle -> flush=1, stage_rst=5'b00110, stall=0; flush_cnt=1; a source address of 0 never stalls.
- debug_en=1 for 10 cycles with one debug_step pulse -> records change on exactly one edge, stage_en=0 otherwise.
- Preload stall_cnt near max (CNT_W=4, 20 stalls) -> stall_cnt holds 15; rst mid-stall -> all records invalid and counters 0 next cycle.
